// File: rtl/int_to_fp_pipe.sv
// Pipelined integer-to-float converter (s32/u32/s64/u64 -> {sign,exp,frac}) on a 3-stage valid/ready pipeline.
// Optional feature macro: INT_TO_FP_FLAGS_EN drives the inexact flag on out_flags[0].
module int_to_fp_pipe #(
  parameter int INT_W = 64,
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [INT_W-1:0]       in_data,
  input  logic [1:0]             in_fmt,
  input  logic [2:0]             in_rm,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out_data,
  output logic [4:0]             out_flags
);

  localparam int OUT_W = 1 + EXP_W + MAN_W;
  localparam int LZ_W  = $clog2(INT_W + 1);
  localparam int RW    = INT_W + MAN_W + 1;
  localparam logic [INT_W-1:0] ONE   = {{(INT_W-1){1'b0}}, 1'b1};
  localparam logic [EXP_W-1:0] BIAS  = {1'b0, {(EXP_W-1){1'b1}}};
  localparam logic [EXP_W-1:0] TOP_E = EXP_W'(INT_W - 1);

  logic                 v1_q, v2_q, v3_q;
  logic                 rdy1_s, rdy2_s;
  logic                 ext_bit_s;
  logic [INT_W-1:0]     op_s;
  logic                 s1_sign_d, s1_sign_q;
  logic [INT_W-1:0]     s1_mag_d, s1_mag_q;
  logic [2:0]           s1_rm_q;
  logic [LZ_W-1:0]      lzc_s;
  logic [INT_W-1:0]     s2_norm_d, s2_norm_q;
  logic [EXP_W-1:0]     s2_exp_d, s2_exp_q;
  logic                 s2_sign_q;
  logic [2:0]           s2_rm_q;
  logic [RW-1:0]        ext_s;
  logic [MAN_W-1:0]     frac_s;
  logic                 g_s, st_s, inc_s;
  logic [MAN_W:0]       sum_s;
  logic [EXP_W-1:0]     exp_fld_s;
  logic [OUT_W-1:0]     data_d, data_q;

  // Ready chain runs backwards from the consumer so a full pipe still advances in one cycle.
  assign rdy2_s    = ~v3_q | out_ready;
  assign rdy1_s    = ~v2_q | rdy2_s;
  assign in_ready  = ~v1_q | rdy1_s;
  assign out_valid = v3_q;
  assign out_data  = data_q;

  // S1: sign detection and two's-complement magnitude; 32-bit formats ignore the upper half.
  always_comb begin
    ext_bit_s = ~in_fmt[0] & in_data[31];
    if (in_fmt[1]) begin
      op_s      = in_data;
      s1_sign_d = ~in_fmt[0] & in_data[INT_W-1];
    end else begin
      op_s      = {{(INT_W-32){ext_bit_s}}, in_data[31:0]};
      s1_sign_d = ext_bit_s;
    end
    if (s1_sign_d) begin
      s1_mag_d = ~op_s + ONE;
    end else begin
      s1_mag_d = op_s;
    end
  end

  // S2: leading-zero count and normalisation; the highest set bit wins the scan.
  always_comb begin
    lzc_s = LZ_W'(INT_W);
    for (int i = 0; i < INT_W; i++) begin
      if (s1_mag_q[i]) begin
        lzc_s = LZ_W'(INT_W - 1 - i);
      end else begin
        lzc_s = lzc_s;
      end
    end
    s2_norm_d = s1_mag_q << lzc_s;
    s2_exp_d  = TOP_E - EXP_W'(lzc_s);
  end

  // S3: round; the two pad bits make G/S vanish when the fraction holds every bit.
  always_comb begin
    ext_s  = {s2_norm_q[INT_W-2:0], {(MAN_W+2){1'b0}}};
    frac_s = ext_s[RW-1 -: MAN_W];
    g_s    = ext_s[RW-1-MAN_W];
    st_s   = |ext_s[RW-2-MAN_W:0];
    case (s2_rm_q)
      3'b001:  inc_s = 1'b0;
      3'b010:  inc_s = s2_sign_q & (g_s | st_s);
      3'b011:  inc_s = ~s2_sign_q & (g_s | st_s);
      3'b100:  inc_s = g_s;
      default: inc_s = g_s & (st_s | frac_s[0]);
    endcase
    sum_s     = {1'b0, frac_s} + {{MAN_W{1'b0}}, inc_s};
    exp_fld_s = s2_exp_q + BIAS + {{(EXP_W-1){1'b0}}, sum_s[MAN_W]};
    // A zero operand leaves the normalised MSB clear.
    if (s2_norm_q[INT_W-1]) begin
      data_d = {s2_sign_q, exp_fld_s, sum_s[MAN_W-1:0]};
    end else begin
      data_d = {OUT_W{1'b0}};
    end
  end

  // Pipeline registers: each stage loads when its downstream slot frees up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      v3_q      <= 1'b0;
      s1_sign_q <= 1'b0;
      s1_mag_q  <= {INT_W{1'b0}};
      s1_rm_q   <= 3'b000;
      s2_sign_q <= 1'b0;
      s2_norm_q <= {INT_W{1'b0}};
      s2_exp_q  <= {EXP_W{1'b0}};
      s2_rm_q   <= 3'b000;
      data_q    <= {OUT_W{1'b0}};
    end else begin
      if (in_ready) begin
        v1_q <= in_valid;
      end
      if (in_ready & in_valid) begin
        s1_sign_q <= s1_sign_d;
        s1_mag_q  <= s1_mag_d;
        s1_rm_q   <= in_rm;
      end
      if (rdy1_s) begin
        v2_q <= v1_q;
      end
      if (rdy1_s & v1_q) begin
        s2_sign_q <= s1_sign_q;
        s2_norm_q <= s2_norm_d;
        s2_exp_q  <= s2_exp_d;
        s2_rm_q   <= s1_rm_q;
      end
      if (rdy2_s) begin
        v3_q <= v2_q;
      end
      if (rdy2_s & v2_q) begin
        data_q <= data_d;
      end
    end
  end

`ifdef INT_TO_FP_FLAGS_EN
  logic nx_d, nx_q;

  assign nx_d      = s2_norm_q[INT_W-1] & (g_s | st_s);
  assign out_flags = {4'b0000, nx_q};

  // Inexact flag travels alongside the S3 result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nx_q <= 1'b0;
    end else if (rdy2_s & v2_q) begin
      nx_q <= nx_d;
    end
  end
`else
  assign out_flags = 5'b00000;
`endif

endmodule

// File: tb/tb_int_to_fp_pipe.sv
// Self-checking bench for int_to_fp_pipe (FP32 defaults): directed table, stall/reset sequences,
// and randomized traffic scored against an arithmetic rounding model.
module tb_int_to_fp_pipe;

  localparam int INT_W = 64;
  localparam int EXP_W = 8;
  localparam int MAN_W = 23;
  localparam int NRAND = 10000;
  localparam int NVEC  = 17;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [1:0]  in_fmt;
  logic [2:0]  in_rm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_flags;

  int checks = 0;
  int errors = 0;
  int n_out  = 0;
  logic [32:0] exp_q[$];

  typedef struct {
    logic [63:0] data;
    logic [1:0]  fmt;
    logic [2:0]  rm;
    logic [31:0] exp_data;
    logic        exp_nx;
  } vec_t;
  vec_t vecs[NVEC];

  int_to_fp_pipe #(.INT_W(INT_W), .EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_fmt(in_fmt), .in_rm(in_rm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_flags(out_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  function automatic logic [4:0] exp_flags(input logic nx);
`ifdef INT_TO_FP_FLAGS_EN
    return {4'b0000, nx};
`else
    return 5'b00000 & {5{nx}};
`endif
  endfunction

  // Reference: exact magnitude, rounded by comparing the discarded remainder against one half ulp.
  function automatic logic [32:0] ref_conv(input logic [63:0] d, input logic [1:0] fmt, input logic [2:0] rm);
    logic        sign;
    logic [64:0] mag, q, rem, half;
    logic        up;
    int          p, sh;
    if (!fmt[1]) begin
      sign = !fmt[0] && d[31];
      mag  = sign ? (65'h1_0000_0000 - {33'b0, d[31:0]}) : {33'b0, d[31:0]};
    end else begin
      sign = !fmt[0] && d[63];
      mag  = sign ? (65'h1_0000_0000_0000_0000 - {1'b0, d}) : {1'b0, d};
    end
    if (mag == 65'd0) return 33'd0;
    p = 0;
    while ((mag >> (p + 1)) != 65'd0) p++;
    rem = 65'd0;
    up  = 1'b0;
    if (p <= 23) begin
      q = mag << (23 - p);
    end else begin
      sh   = p - 23;
      q    = mag >> sh;
      rem  = mag - (q << sh);
      half = 65'd1 << (sh - 1);
      case (rm)
        3'd1:    up = 1'b0;
        3'd2:    up = sign && (rem != 65'd0);
        3'd3:    up = !sign && (rem != 65'd0);
        3'd4:    up = (rem >= half);
        default: up = (rem > half) || ((rem == half) && q[0]);
      endcase
    end
    q = q + {64'd0, up};
    if (q == (65'd1 << 24)) begin
      q = 65'd1 << 23;
      p++;
    end
    return {rem != 65'd0, sign, 8'(p + 127), q[22:0]};
  endfunction

  function automatic logic [63:0] rand_data();
    logic [63:0] r;
    int k;
    r = {$urandom, $urandom};
    case ($urandom_range(0, 4))
      0: return r;
      1: return r >> $urandom_range(0, 63);
      2: return 64'($urandom_range(0, 300));
      3: begin
        k = $urandom_range(24, 63);
        return (64'd1 << k) + ((64'd1 << (k - 24)) * 64'($urandom_range(0, 3)));
      end
      default: begin
        k = $urandom_range(0, 3);
        if (k == 0) return 64'h8000_0000_0000_0000;
        else if (k == 1) return {r[63:32], 32'h8000_0000};
        else if (k == 2) return 64'hFFFF_FFFF_FFFF_FFFF;
        else return {r[63:32], 32'hFFFF_FFFF};
      end
    endcase
  endfunction

  // Scoreboard: record accepted operands, check every delivered result and hold stability.
  logic        hold_chk = 1'b0;
  logic [31:0] hold_data;
  logic [4:0]  hold_flags;
  always @(negedge clk) begin
    logic [32:0] e;
    if (!rst) begin
      if (hold_chk) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_data", 64'(out_data), 64'(hold_data));
        chk("hold_flags", 64'(out_flags), 64'(hold_flags));
      end
      hold_chk   = out_valid && !out_ready;
      hold_data  = out_data;
      hold_flags = out_flags;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %0h, expected no result", out_data);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", 64'(out_data), 64'(e[31:0]));
          chk("out_flags", 64'(out_flags), 64'(exp_flags(e[32])));
          n_out++;
        end
      end
      if (in_valid && in_ready) exp_q.push_back(ref_conv(in_data, in_fmt, in_rm));
    end else begin
      hold_chk = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, idx, base, cyc, sent;
    logic acc;
    logic [63:0] sdat[5];

    vecs[0]  = '{64'd1,                   2'b00, 3'd0, 32'h3F800000, 1'b0};
    vecs[1]  = '{64'h1234_5678_FFFF_FFFF, 2'b00, 3'd0, 32'hBF800000, 1'b0};
    vecs[2]  = '{64'h0000_0000_FFFF_FFFF, 2'b01, 3'd0, 32'h4F800000, 1'b1};
    vecs[3]  = '{64'h0000_0000_FFFF_FFFF, 2'b01, 3'd1, 32'h4F7FFFFF, 1'b1};
    vecs[4]  = '{64'h0000_0000_0100_0001, 2'b01, 3'd0, 32'h4B800000, 1'b1};
    vecs[5]  = '{64'h0000_0000_0100_0001, 2'b01, 3'd3, 32'h4B800001, 1'b1};
    vecs[6]  = '{64'h0000_0000_0100_0001, 2'b01, 3'd4, 32'h4B800001, 1'b1};
    vecs[7]  = '{64'h0000_0000_0100_0001, 2'b01, 3'd2, 32'h4B800000, 1'b1};
    vecs[8]  = '{64'h8000_0000_0000_0000, 2'b10, 3'd0, 32'hDF000000, 1'b0};
    vecs[9]  = '{64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 3'd0, 32'h5F800000, 1'b1};
    vecs[10] = '{64'd0,                   2'b10, 3'd3, 32'h00000000, 1'b0};
    vecs[11] = '{64'h0000_0000_8000_0000, 2'b00, 3'd0, 32'hCF000000, 1'b0};
    vecs[12] = '{64'hDEAD_BEEF_0000_0005, 2'b01, 3'd0, 32'h40A00000, 1'b0};
    vecs[13] = '{64'h0000_0000_FFFF_FFFF, 2'b01, 3'd7, 32'h4F800000, 1'b1};
    vecs[14] = '{64'h0000_0000_FEFF_FFFF, 2'b00, 3'd2, 32'hCB800001, 1'b1};
    vecs[15] = '{64'h0000_0000_FEFF_FFFF, 2'b00, 3'd3, 32'hCB800000, 1'b1};
    vecs[16] = '{64'h0000_0000_0100_0003, 2'b01, 3'd0, 32'h4B800002, 1'b1};

    rst = 1'b1; in_valid = 1'b0; in_data = 64'd0; in_fmt = 2'b00; in_rm = 3'd0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_flags", 64'(out_flags), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;

    // Directed table, one operand at a time so latency is observable.
    for (int i = 0; i < NVEC; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = vecs[i].data; in_fmt = vecs[i].fmt; in_rm = vecs[i].rm; out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (!out_valid && lat < 8);
      chk($sformatf("latency[%0d]", i), 64'(lat), 64'd3);
      chk($sformatf("vec_data[%0d]", i), 64'(out_data), 64'(vecs[i].exp_data));
      chk($sformatf("vec_flags[%0d]", i), 64'(out_flags), 64'(exp_flags(vecs[i].exp_nx)));
    end

    // Stall: five back-to-back operands against a blocked consumer.
    for (int i = 0; i < 5; i++) sdat[i] = 64'(i * 1000 + 7);
    @(posedge clk); #1;
    out_ready = 1'b0; idx = 0; base = n_out;
    in_valid = 1'b1; in_data = sdat[0]; in_fmt = 2'b01; in_rm = 3'd0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
      if (idx < 5) in_data = sdat[idx];
      else in_valid = 1'b0;
    end
    chk("stall_accepted", 64'(idx), 64'd3);
    chk("stall_in_ready", 64'(in_ready), 64'd0);
    chk("stall_out_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    cyc = 0;
    while ((idx < 5 || exp_q.size() != 0) && cyc < 30) begin
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
      cyc++;
      if (idx < 5) in_data = sdat[idx];
      else in_valid = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("stall_delivered", 64'(n_out - base), 64'd5);
    chk("stall_queue_empty", 64'(exp_q.size()), 64'd0);

    // Reset with operands in flight and one result already presented.
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 64'd11; in_fmt = 2'b01; in_rm = 3'd0;
    @(posedge clk); #1;
    in_data = 64'd22;
    @(posedge clk); #1;
    in_data = 64'd33;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 64'(out_valid), 64'd0);
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    lat = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) lat++;
    end
    chk("no_stale_result", 64'(lat), 64'd0);

    // Randomized traffic with random back-pressure.
    sent = 0; base = n_out; cyc = 0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (sent < NRAND && cyc < 60000) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) sent++;
      if (!in_valid || acc) begin
        if (sent < NRAND && $urandom_range(0, 9) < 8) begin
          in_valid = 1'b1;
          in_data  = rand_data();
          in_fmt   = 2'($urandom_range(0, 3));
          in_rm    = 3'($urandom_range(0, 7));
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 9) < 7);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("rand_sent", 64'(sent), 64'(NRAND));
    chk("rand_delivered", 64'(n_out - base), 64'(NRAND));
    chk("rand_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
